// File: rtl/mp_add_sequencer.sv
// Multi-precision add/subtract sequencer: streams 32-bit limbs LS-first through one time-shared 32-bit adder.
// Latency: each result limb is registered and visible one cycle after its input limb is accepted.
// Backpressure: a held result with out_ready low drops in_ready; DRAIN waits for the last limb to be taken.

// 32-bit adder with a parallel-prefix (Kogge-Stone) carry tree.
// The carry-in is folded in after the tree, so the tree only computes
// group generate/propagate for every prefix [i:0].
module fulladder_with_tree_carry_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  // Per-level group generate/propagate; level k covers spans of 2^k bits.
  logic [31:0] g0, p0;
  logic [31:0] g1, p1;
  logic [31:0] g2, p2;
  logic [31:0] g3, p3;
  logic [31:0] g4, p4;
  logic [31:0] g5, p5;
  logic [32:0] carry;

  // Bitwise generate/propagate.
  assign g0 = a & b;
  assign p0 = a ^ b;

  // Each level combines bit i with bit i-span. Bits below the span already
  // hold complete prefixes, so they pass through (zero generate shifted in,
  // ones shifted into the propagate term).
  assign g1 = g0 | (p0 & {g0[30:0], 1'b0});
  assign p1 = p0 & {p0[30:0], 1'b1};

  assign g2 = g1 | (p1 & {g1[29:0], 2'b0});
  assign p2 = p1 & {p1[29:0], 2'b11};

  assign g3 = g2 | (p2 & {g2[27:0], 4'h0});
  assign p3 = p2 & {p2[27:0], 4'hF};

  assign g4 = g3 | (p3 & {g3[23:0], 8'h00});
  assign p4 = p3 & {p3[23:0], 8'hFF};

  assign g5 = g4 | (p4 & {g4[15:0], 16'h0000});
  assign p5 = p4 & {p4[15:0], 16'hFFFF};

  // carry[i] is the carry into bit i; carry[32] is the adder carry-out.
  assign carry = {g5 | (p5 & {32{cin}}), cin};
  assign sum   = p0 ^ carry[31:0];
  assign cout  = carry[32];

endmodule

module mp_add_sequencer #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             carry_out,
  output logic             overflow
);

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             sub_q, sub_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             carry_q, carry_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_sum_q, out_sum_d;
  logic             out_last_q, out_last_d;
  logic             done_q, done_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;

  logic [31:0]      b_eff;
  logic [31:0]      add_sum;
  logic             add_cout;
  logic             ovf_now;
  logic             accept;
  logic             out_take;

  // Subtraction is A + ~B + 1: the +1 enters as the initial carry (set on start).
  assign b_eff = sub_q ? ~in_b : in_b;

  fulladder_with_tree_carry_32 u_adder (
    .a    (in_a),
    .b    (b_eff),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Signed overflow of this limb if it turns out to be the top one.
  assign ovf_now = (in_a[31] == b_eff[31]) & (add_sum[31] != in_a[31]);

  // A new limb may enter whenever the output register is empty or is being
  // drained this very cycle, which keeps one limb per cycle at full rate.
  assign in_ready = (state_q == ST_RUN) & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign out_take = out_valid_q & out_ready;

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

  // Next-state and datapath control for the IDLE/RUN/DRAIN sequencer.
  always_comb begin
    state_d     = state_q;
    sub_d       = sub_q;
    rem_d       = rem_q;
    carry_d     = carry_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;

    unique case (state_q)
      ST_IDLE: begin
        // A zero-length request is dropped without any visible effect.
        if (start && (len != '0)) begin
          state_d     = ST_RUN;
          sub_d       = sub;
          rem_d       = len;
          carry_d     = sub;
          carry_out_d = 1'b0;
          overflow_d  = 1'b0;
        end
      end

      ST_RUN: begin
        if (out_take) begin
          out_valid_d = 1'b0;
        end
        if (accept) begin
          out_valid_d = 1'b1;
          out_sum_d   = add_sum;
          carry_d     = add_cout;
          rem_d       = rem_q - ONE;
          if (rem_q == ONE) begin
            out_last_d  = 1'b1;
            carry_out_d = add_cout;
            overflow_d  = ovf_now;
            state_d     = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        // Only the final limb is pending here; completion is its hand-off.
        if (out_take) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          done_d      = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; synchronous reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sub_q       <= 1'b0;
      rem_q       <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sub_q       <= sub_d;
      rem_q       <= rem_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule

// File: tb/tb_mp_add_sequencer.sv
`timescale 1ns/1ps
// Bench for mp_add_sequencer: limb-level bignum model, random and directed operations.
// Outputs are sampled on the falling edge; inputs change 1ns after the rising edge.
// A random consumer applies backpressure; every output hand-off is scored against the model.
module tb_mp_add_sequencer;

  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             sub;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_sum;
  logic             out_last;
  logic             busy;
  logic             done;
  logic             carry_out;
  logic             overflow;

  mp_add_sequencer #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sub       (sub),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state
  logic [32:0] exp_q[$];      // {last, sum} per expected result limb
  logic [31:0] got_q[$];      // result limbs as handed off, for literal checks
  logic        exp_cy = 1'b0;
  logic        exp_ov = 1'b0;
  int          n_done = 0;
  logic [31:0] op_a[256];
  logic [31:0] op_b[256];
  int          rdy_pct  = 100;
  int          hold_cnt = 0;
  int          tput_span = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  function automatic logic [31:0] rnd_limb();
    case ($urandom_range(5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Consumer: random out_ready, with forced stall windows on request.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hold_cnt > 0) begin
        out_ready = 1'b0;
        hold_cnt--;
      end else begin
        out_ready = (int'($urandom_range(99)) < rdy_pct);
      end
    end
  end

  // Compare process: runs every falling edge outside reset.
  initial begin
    logic        prev_last_hs;
    logic        prev_stall;
    logic [31:0] prev_sum;
    logic        prev_lastbit;
    logic [32:0] e;
    prev_last_hs = 1'b0;
    prev_stall   = 1'b0;
    prev_sum     = '0;
    prev_lastbit = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        prev_last_hs = 1'b0;
        prev_stall   = 1'b0;
      end else begin
        check("done_pulse", done, prev_last_hs);
        if (done === 1'b1) begin
          n_done++;
          check("carry_out_at_done", carry_out, exp_cy);
          check("overflow_at_done", overflow, exp_ov);
        end
        if (prev_stall) begin
          check("stall_valid", out_valid, 1'b1);
          check("stall_sum", out_sum, prev_sum);
          check("stall_last", out_last, prev_lastbit);
        end
        if (out_valid === 1'b1 && out_ready === 1'b0) begin
          check("in_ready_stall", in_ready, 1'b0);
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            timeout("unexpected_out_limb");
          end else begin
            e = exp_q.pop_front();
            check("out_sum", out_sum, e[31:0]);
            check("out_last", out_last, e[32]);
            got_q.push_back(out_sum);
          end
        end
        prev_last_hs = out_valid & out_ready & out_last;
        prev_stall   = out_valid & ~out_ready;
        prev_sum     = out_sum;
        prev_lastbit = out_last;
      end
    end
  end

  // One operation on op_a/op_b[0..n-1]. abort_after>0 resets the DUT once that many limbs are accepted.
  task automatic run_op(input int n, input logic s, input int gap_pct,
                        input bit stall_first, input bit poke_start, input int abort_after);
    logic        c;
    logic [31:0] bb;
    logic [32:0] t;
    longint      sv;
    int          i, cyc, budget, nd0, first_acc, last_acc;
    bit          poked;

    // Bignum model: limb-wise sum with a rippled carry, signed range check on top limb.
    c = s;
    for (int k = 0; k < n; k++) begin
      bb = s ? ~op_b[k] : op_b[k];
      t  = {1'b0, op_a[k]} + {1'b0, bb} + 33'(c);
      if (k == n - 1) begin
        sv     = longint'($signed(op_a[k])) + longint'($signed(bb)) + longint'(c);
        exp_ov = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
        exp_cy = t[32];
      end
      exp_q.push_back({(k == n - 1), t[31:0]});
      c = t[32];
    end

    budget = 0;
    while (busy !== 1'b0) begin
      @(negedge clk);
      if (++budget > 2000) begin
        timeout("wait_idle");
        return;
      end
    end
    nd0 = n_done;

    @(posedge clk);
    #1;
    start = 1'b1;
    sub   = s;
    len   = n[LEN_W-1:0];
    @(posedge clk);
    #1;
    start = 1'b0;
    sub   = $urandom;
    len   = $urandom;
    @(negedge clk);
    check("busy_after_start", busy, 1'b1);
    check("carry_out_cleared", carry_out, 1'b0);
    check("overflow_cleared", overflow, 1'b0);

    i = 0; cyc = 0; first_acc = -1; last_acc = -1; poked = 0;
    while (i < n) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (poke_start && i == 1 && !poked) begin
        start = 1'b1;
        sub   = ~s;
        len   = LEN_W'(n + 3);
        poked = 1;
      end
      if (int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
      end else begin
        in_valid = 1'b1;
        in_a     = op_a[i];
        in_b     = op_b[i];
      end
      @(negedge clk);
      if (in_valid && in_ready === 1'b1) begin
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        i++;
        if (i == 1 && stall_first) hold_cnt = 3;
        if (i == abort_after) break;
      end
      cyc++;
      if (cyc > 5000) begin
        timeout("limb_accept");
        return;
      end
    end
    tput_span = last_acc - first_acc;

    @(posedge clk);
    #1;
    in_valid = 1'b0;
    start    = 1'b0;

    if (abort_after > 0) begin
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_in_ready", in_ready, 1'b0);
      check("abort_out_valid", out_valid, 1'b0);
      check("abort_out_sum", out_sum, 32'h0);
      check("abort_out_last", out_last, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_carry_out", carry_out, 1'b0);
      check("abort_overflow", overflow, 1'b0);
      return;
    end

    budget = 0;
    while (n_done == nd0) begin
      @(negedge clk);
      if (++budget > 3000) begin
        timeout("wait_done");
        return;
      end
    end
    check("busy_after_done", busy, 1'b0);
  endtask

  // Global time limit.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst      = 1'b1;
    start    = 1'b0;
    sub      = 1'b0;
    len      = '0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_sum", out_sum, 32'h0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_carry_out", carry_out, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 2-limb add: all-ones + 1 wraps to zero with a final carry.
    rdy_pct = 100;
    op_a[0] = 32'hFFFF_FFFF; op_a[1] = 32'hFFFF_FFFF;
    op_b[0] = 32'h0000_0001; op_b[1] = 32'h0000_0000;
    got_q.delete();
    run_op(2, 1'b0, 0, 0, 0, 0);
    check("t1_size", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("t1_limb0", got_q[0], 32'h0000_0000);
      check("t1_limb1", got_q[1], 32'h0000_0000);
    end
    check("t1_carry", carry_out, 1'b1);
    check("t1_ovf", overflow, 1'b0);

    // 2-limb sub without borrow.
    op_a[0] = 32'h0000_0000; op_a[1] = 32'h0000_0001;
    op_b[0] = 32'h0000_0001; op_b[1] = 32'h0000_0000;
    got_q.delete();
    run_op(2, 1'b1, 0, 0, 0, 0);
    check("t2_size", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("t2_limb0", got_q[0], 32'hFFFF_FFFF);
      check("t2_limb1", got_q[1], 32'h0000_0000);
    end
    check("t2_carry", carry_out, 1'b1);

    // 2-limb sub 0 - 1: borrow out.
    op_a[0] = 32'h0; op_a[1] = 32'h0;
    op_b[0] = 32'h1; op_b[1] = 32'h0;
    got_q.delete();
    run_op(2, 1'b1, 0, 0, 0, 0);
    check("t3_size", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("t3_limb0", got_q[0], 32'hFFFF_FFFF);
      check("t3_limb1", got_q[1], 32'hFFFF_FFFF);
    end
    check("t3_carry", carry_out, 1'b0);

    // 1-limb signed overflow.
    op_a[0] = 32'h7FFF_FFFF; op_b[0] = 32'h0000_0001;
    got_q.delete();
    run_op(1, 1'b0, 0, 0, 0, 0);
    check("t4_size", got_q.size(), 1);
    if (got_q.size() == 1) check("t4_limb0", got_q[0], 32'h8000_0000);
    check("t4_carry", carry_out, 1'b0);
    check("t4_ovf", overflow, 1'b1);

    // 4-limb add with a 3-cycle output stall after limb 1 and input gaps.
    for (int k = 0; k < 4; k++) begin op_a[k] = rnd_limb(); op_b[k] = rnd_limb(); end
    run_op(4, 1'b0, 40, 1, 0, 0);

    // Full-rate 4-limb add: four accepts on consecutive cycles.
    for (int k = 0; k < 4; k++) begin op_a[k] = rnd_limb(); op_b[k] = rnd_limb(); end
    run_op(4, 1'b0, 0, 0, 0, 0);
    check("t5_throughput_span", tput_span, 3);

    // start pulsed mid-operation with different sub/len is ignored.
    for (int k = 0; k < 3; k++) begin op_a[k] = rnd_limb(); op_b[k] = rnd_limb(); end
    run_op(3, 1'b1, 20, 0, 1, 0);
    repeat (3) begin
      @(negedge clk);
      check("t6_stays_idle", busy, 1'b0);
    end

    // start with len=0 is ignored; flags of the previous op persist.
    @(posedge clk);
    #1;
    start = 1'b1;
    len   = '0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t7_len0_idle", busy, 1'b0);
    end
    check("t7_flag_hold", carry_out, exp_cy);

    // Reset after limb 2 of 4, then 3 + 4.
    for (int k = 0; k < 4; k++) begin op_a[k] = rnd_limb(); op_b[k] = rnd_limb(); end
    run_op(4, 1'b0, 0, 0, 0, 2);
    op_a[0] = 32'd3; op_b[0] = 32'd4;
    got_q.delete();
    run_op(1, 1'b0, 0, 0, 0, 0);
    check("t8_size", got_q.size(), 1);
    if (got_q.size() == 1) check("t8_limb0", got_q[0], 32'h0000_0007);
    check("t8_carry", carry_out, 1'b0);

    // Longest operation at full rate.
    for (int k = 0; k < 255; k++) begin op_a[k] = rnd_limb(); op_b[k] = rnd_limb(); end
    rdy_pct = 100;
    run_op(255, 1'b1, 0, 0, 0, 0);
    check("t9_throughput_span", tput_span, 254);

    // Random operations with random backpressure and gaps.
    for (int r = 0; r < 40; r++) begin
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin op_a[k] = rnd_limb(); op_b[k] = rnd_limb(); end
      rdy_pct = $urandom_range(30, 100);
      run_op(n, 1'($urandom_range(1)), $urandom_range(0, 50), 0, 0, 0);
    end

    rdy_pct = 100;
    repeat (5) @(posedge clk);
    check("exp_queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
